multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mc_ctrl_pkg.sv | 52 +++++
 rtl/mc_opdec.sv | 67 ++++++
 rtl/multicycle_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode/funct
// fields, ALU operation codes, datapath select encodings and decode results.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_IMMEX, S_IMMWB, S_BRANCH, S_JUMP, S_TRAP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J     = 6'b000010, OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE   = 6'b000101, OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111, OP_ADDI  = 6'b001000, OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010, OP_SLTIU = 6'b001011, OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101, OP_XORI  = 6'b001110, OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000, OP_LH    = 6'b100001, OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100, OP_LHU   = 6'b100101, OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001, OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000, FN_SRL  = 6'b000010, FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000, FN_JALR = 6'b001001, FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUB = 6'b100010, FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND = 6'b100100, FN_OR   = 6'b100101, FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111, FN_SLT  = 6'b101010, FN_SLTU = 6'b101011;

    localparam int ALU_W = 4;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
    localparam logic [ALU_W-1:0] ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;
    // Compare codes: the ALU yields a zero result exactly when the condition holds.
    localparam logic [ALU_W-1:0] ALU_LEZ = 4'd12, ALU_GTZ = 4'd13;

    localparam logic [1:0] SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11;
    localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_REG = 2'b11;

    typedef enum logic [3:0] {
        CLS_ILLEGAL, CLS_LOAD, CLS_STORE, CLS_RTYPE, CLS_JR, CLS_JALR,
        CLS_IMM, CLS_BRANCH, CLS_J, CLS_JAL
    } cls_e;

    typedef enum logic [1:0] {BR_EQ, BR_NE, BR_LEZ, BR_GTZ} br_e;

    // half[0]: halfword access, half[1]: unsigned halfword; b: byte, lbu: unsigned byte.
    typedef struct packed {
        cls_e             cls;
        logic [ALU_W-1:0] aluop;
        br_e              br;
        logic [1:0]       half;
        logic             b;
        logic             lbu;
    } dec_t;

endpackage

// File: rtl/mc_opdec.sv
// Combinational op/funct classification: instruction class, ALU code,
// branch kind, sub-word controls and legality.
module mc_opdec
    import mc_ctrl_pkg::*;
#(
    parameter int HAS_SUBWORD = 1
) (
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output dec_t       dec,
    output logic       legal
);

    always_comb begin
        dec = '0;
        case (op)
            OP_RTYPE: begin
                dec.cls = CLS_RTYPE;
                case (funct)
                    FN_ADD, FN_ADDU: dec.aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.aluop = ALU_SUB;
                    FN_AND:          dec.aluop = ALU_AND;
                    FN_OR:           dec.aluop = ALU_OR;
                    FN_XOR:          dec.aluop = ALU_XOR;
                    FN_NOR:          dec.aluop = ALU_NOR;
                    FN_SLT:          dec.aluop = ALU_SLT;
                    FN_SLTU:         dec.aluop = ALU_SLTU;
                    FN_SLL:          dec.aluop = ALU_SLL;
                    FN_SRL:          dec.aluop = ALU_SRL;
                    FN_SRA:          dec.aluop = ALU_SRA;
                    FN_JR:           dec.cls = CLS_JR;
                    FN_JALR:         dec.cls = CLS_JALR;
                    default:         dec.cls = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin dec.cls = CLS_IMM; dec.aluop = ALU_ADD;  end
            OP_SLTI:           begin dec.cls = CLS_IMM; dec.aluop = ALU_SLT;  end
            OP_SLTIU:          begin dec.cls = CLS_IMM; dec.aluop = ALU_SLTU; end
            OP_ANDI:           begin dec.cls = CLS_IMM; dec.aluop = ALU_AND;  end
            OP_ORI:            begin dec.cls = CLS_IMM; dec.aluop = ALU_OR;   end
            OP_XORI:           begin dec.cls = CLS_IMM; dec.aluop = ALU_XOR;  end
            OP_LUI:            begin dec.cls = CLS_IMM; dec.aluop = ALU_LUI;  end
            OP_BEQ:  begin dec.cls = CLS_BRANCH; dec.aluop = ALU_SUB; dec.br = BR_EQ;  end
            OP_BNE:  begin dec.cls = CLS_BRANCH; dec.aluop = ALU_SUB; dec.br = BR_NE;  end
            OP_BLEZ: begin dec.cls = CLS_BRANCH; dec.aluop = ALU_LEZ; dec.br = BR_LEZ; end
            OP_BGTZ: begin dec.cls = CLS_BRANCH; dec.aluop = ALU_GTZ; dec.br = BR_GTZ; end
            OP_J:    dec.cls = CLS_J;
            OP_JAL:  dec.cls = CLS_JAL;
            OP_LW:   dec.cls = CLS_LOAD;
            OP_LH:   begin dec.cls = CLS_LOAD; dec.half = 2'b01; end
            OP_LHU:  begin dec.cls = CLS_LOAD; dec.half = 2'b11; end
            OP_LB:   begin dec.cls = CLS_LOAD; dec.b = 1'b1; end
            OP_LBU:  begin dec.cls = CLS_LOAD; dec.b = 1'b1; dec.lbu = 1'b1; end
            OP_SW:   dec.cls = CLS_STORE;
            OP_SH:   begin dec.cls = CLS_STORE; dec.half = 2'b01; end
            OP_SB:   begin dec.cls = CLS_STORE; dec.b = 1'b1; end
            default: dec.cls = CLS_ILLEGAL;
        endcase
        // Without sub-word support every sub-word access is an illegal opcode.
        if (HAS_SUBWORD == 0 && (dec.half != 2'b00 || dec.b)) begin
            dec = '0;
        end
    end

    assign legal = (dec.cls != CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller: FSM, stall/timeout counter and sticky error
// flags; outputs decode registered state plus the opcode class latched in DECODE.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 4,
    parameter int MAX_WAIT    = 15,
    parameter int HAS_SUBWORD = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               irwrite,
    output logic               iord,
    output logic               pcwrite,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [ALUOP_W-1:0] aluop,
    output logic               mem_req,
    output logic               mem_we,
    output logic [1:0]         half,
    output logic               b,
    output logic               lbu,
    output logic               link,
    output logic               illegal,
    output logic               timeout,
    output logic               busy,
    output state_e             state
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    state_e           state_q, state_d;
    dec_t             dec, dec_q;
    logic             legal, waiting, stall_hit, taken;
    logic [CNT_W-1:0] cnt;
    logic             illegal_q, timeout_q;
    logic [ALU_W-1:0] alu_code;

    mc_opdec #(.HAS_SUBWORD(HAS_SUBWORD)) u_opdec (
        .op(op), .funct(funct), .dec(dec), .legal(legal)
    );

    assign waiting   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // mem_ready in the limit cycle completes the transfer instead of trapping.
    assign stall_hit = (MAX_WAIT > 0) && waiting && !mem_ready && (cnt == LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (dec.cls)
                    CLS_LOAD, CLS_STORE:              state_d = S_MEMADR;
                    CLS_RTYPE:                        state_d = S_EXEC;
                    CLS_IMM:                          state_d = S_IMMEX;
                    CLS_BRANCH:                       state_d = S_BRANCH;
                    CLS_JR, CLS_JALR, CLS_J, CLS_JAL: state_d = S_JUMP;
                    default:                          state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (dec_q.cls == CLS_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_IMMEX:  state_d = S_IMMWB;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
        if (stall_hit) state_d = S_TRAP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            dec_q     <= '0;
            cnt       <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                dec_q <= dec;
                if (!legal) illegal_q <= 1'b1;
            end
            if (stall_hit) timeout_q <= 1'b1;
            if (state_d != state_q) cnt <= '0;
            else if (waiting && !mem_ready && cnt != '1) cnt <= cnt + CNT_W'(1);
        end
    end

    // BLEZ/BGTZ use compare codes whose zero result means the branch is taken.
    always_comb begin
        case (dec_q.br)
            BR_NE:   taken = !zero;
            default: taken = zero;
        endcase
    end

    always_comb begin
        irwrite  = 1'b0; iord   = 1'b0; pcwrite = 1'b0; regwrite = 1'b0;
        regdst   = 1'b0; memtoreg = 1'b0; alusrca = 1'b0;
        alusrcb  = SRCB_REG; pcsrc = PC_ALU; alu_code = ALU_ADD;
        mem_req  = 1'b0; mem_we = 1'b0; half = 2'b00; b = 1'b0; lbu = 1'b0; link = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = SRCB_FOUR;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: alusrcb = SRCB_IMM_SH2;
                S_MEMADR: begin alusrca = 1'b1; alusrcb = SRCB_IMM; end
                S_MEMRD, S_MEMWR: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (state_q == S_MEMWR);
                    half = dec_q.half; b = dec_q.b; lbu = dec_q.lbu;
                end
                S_MEMWB: begin
                    regwrite = 1'b1; memtoreg = 1'b1;
                    half = dec_q.half; b = dec_q.b; lbu = dec_q.lbu;
                end
                S_EXEC:  begin alusrca = 1'b1; alusrcb = SRCB_REG; alu_code = dec_q.aluop; end
                S_ALUWB: begin regwrite = 1'b1; regdst = 1'b1; end
                S_IMMEX: begin alusrca = 1'b1; alusrcb = SRCB_IMM; alu_code = dec_q.aluop; end
                S_IMMWB: regwrite = 1'b1;
                S_BRANCH: begin
                    alusrca  = 1'b1;
                    alu_code = dec_q.aluop;
                    pcsrc    = PC_ALUOUT;
                    pcwrite  = taken;
                end
                S_JUMP: begin
                    pcwrite  = 1'b1;
                    pcsrc    = (dec_q.cls == CLS_JR || dec_q.cls == CLS_JALR) ? PC_REG : PC_JUMP;
                    link     = (dec_q.cls == CLS_JAL || dec_q.cls == CLS_JALR);
                    regwrite = link;
                    regdst   = (dec_q.cls == CLS_JALR);
                end
                default: ;
            endcase
        end
    end

    assign aluop   = ALUOP_W'(alu_code);
    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign busy    = (state_q != S_FETCH);
    assign state   = state_q;

endmodule
